// File: rtl/frame_gate_controller_pkg.sv
// rtl/frame_gate_controller_pkg.sv - shared state encoding for the frame gate controller
package frame_gate_controller_pkg;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        WAIT_IDLE = 3'd1,
        ARMED     = 3'd2,
        PASS      = 3'd3,
        SKIP      = 3'd4
    } fgc_state_e;

endpackage

// File: rtl/vsync_edge_detect.sv
// rtl/vsync_edge_detect.sv - one-cycle registered vsync with rise/fall strobes
module vsync_edge_detect (
    input  logic clock,
    input  logic nreset,
    input  logic vsync_in,
    output logic rise,
    output logic fall
);

    logic vsync_q;
    logic vsync_d;

    always_comb vsync_d = vsync_in;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) vsync_q <= 1'b0;
        else         vsync_q <= vsync_d;
    end

    assign rise = vsync_in & ~vsync_q;
    assign fall = ~vsync_in & vsync_q;

endmodule

// File: rtl/frame_gate_controller.sv
// rtl/frame_gate_controller.sv - gates, decimates and drops whole frames toward the UART buffer
module frame_gate_controller
    import frame_gate_controller_pkg::*;
#(
    parameter int SKIP_W      = 4,
    parameter int FRAME_CNT_W = 16,
    parameter int DROP_CNT_W  = 8
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic                   init_done,
    input  logic                   buf_ready,
    input  logic [SKIP_W-1:0]      skip_n,
    input  logic                   vsync_in,
    input  logic                   data_in_valid,
    input  logic [7:0]             data_in,
    output logic                   vsync_out,
    output logic                   data_out_valid,
    output logic [7:0]             data_out,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [DROP_CNT_W-1:0]  drop_count,
    output logic [2:0]             state
);

    logic rise;
    logic fall;

    vsync_edge_detect u_edge (
        .clock    (clock),
        .nreset   (nreset),
        .vsync_in (vsync_in),
        .rise     (rise),
        .fall     (fall)
    );

    fgc_state_e             state_q, state_d;
    logic [SKIP_W-1:0]      skip_cnt_q, skip_cnt_d;
    logic                   vsync_out_q, vsync_out_d;
    logic                   valid_q, valid_d;
    logic [7:0]             data_out_q, data_out_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic [DROP_CNT_W-1:0]  drop_count_q, drop_count_d;

    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        vsync_out_d   = 1'b0;
        valid_d       = 1'b0;
        data_out_d    = data_in;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        // Losing camera init aborts everything, including a frame in flight.
        if (!init_done) begin
            state_d    = WAIT_INIT;
            skip_cnt_d = '0;
        end else begin
            case (state_q)
                WAIT_INIT: state_d = WAIT_IDLE;
                WAIT_IDLE: if (!vsync_in) state_d = ARMED;
                ARMED: begin
                    if (rise) begin
                        if (skip_cnt_q != '0) begin
                            state_d    = SKIP;
                            skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                        end else if (buf_ready) begin
                            state_d     = PASS;
                            skip_cnt_d  = skip_n;
                            vsync_out_d = 1'b1;
                            valid_d     = data_in_valid;
                        end else begin
                            state_d = SKIP;
                            if (!(&drop_count_q)) drop_count_d = drop_count_q + DROP_CNT_W'(1);
                        end
                    end
                end
                PASS: begin
                    if (fall) begin
                        state_d       = ARMED;
                        frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                    end else begin
                        vsync_out_d = 1'b1;
                        valid_d     = data_in_valid;
                    end
                end
                SKIP: if (fall) state_d = ARMED;
                default: state_d = WAIT_INIT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q       <= WAIT_INIT;
            skip_cnt_q    <= '0;
            vsync_out_q   <= 1'b0;
            valid_q       <= 1'b0;
            data_out_q    <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            vsync_out_q   <= vsync_out_d;
            valid_q       <= valid_d;
            data_out_q    <= data_out_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign vsync_out      = vsync_out_q;
    assign data_out_valid = valid_q;
    assign data_out       = data_out_q;
    assign frame_count    = frame_count_q;
    assign drop_count     = drop_count_q;
    assign state          = state_q;

endmodule

// File: doc/frame_gate_controller.md
Name: frame_gate_controller

Overview:
- Sequences the compressed-frame stream between the JPEG/frame-end-stuffer path and the SPRAM UART dual buffer.
- Holds the datapath closed until camera I2C init completes, then opens it only on frame boundaries.
- Decimates frames by a runtime skip count, and drops whole frames when the output buffer cannot accept one.
- Exports frame and drop counters for debug LEDs/MCU.

Parameters:
SKIP_W, 4, width of skip_n (pass 1 of every skip_n+1 frames)
FRAME_CNT_W, 16, width of frame_count (wraps)
DROP_CNT_W, 8, width of drop_count (saturates)

Ports:
clock  in  1  system clock (osc_12m domain)
nreset  in  1  reset, asynchronous, active-low
init_done  in  1  high once camera I2C initializer is no longer active
buf_ready  in  1  output buffer can accept a new frame; sampled only at frame start
skip_n  in  SKIP_W  decimation setting; sampled at each passed-frame start
vsync_in  in  1  active-high frame envelope from stuffer
data_in_valid  in  1  byte strobe
data_in  in  8  byte
vsync_out  out  1  gated frame envelope to buffer
data_out_valid  out  1  gated byte strobe
data_out  out  8  registered copy of data_in
frame_count  out  FRAME_CNT_W  frames fully passed
drop_count  out  DROP_CNT_W  frames dropped for !buf_ready
state  out  3  current FSM state (debug)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, port nreset.
- Reset values: vsync_out=0, data_out_valid=0, data_out=0, frame_count=0, drop_count=0, state=WAIT_INIT, skip_cnt=0, vsync_q=0.
- Edge detection:
  - vsync_q is a 1-cycle registered copy of vsync_in.
  - rise = vsync_in & ~vsync_q; fall = ~vsync_in & vsync_q.
- Outputs are registered; latency from inputs to outputs is exactly 1 cycle.
- data_out <= data_in every cycle. It is only meaningful with data_out_valid.
- States: WAIT_INIT(0), WAIT_IDLE(1), ARMED(2), PASS(3), SKIP(4).
- WAIT_INIT: outputs valid/vsync low. When init_done=1, go to WAIT_IDLE.
- WAIT_IDLE: wait for vsync_in=0, then go to ARMED. This discards any frame already in progress.
- ARMED: on rise, make the decision combinationally in the same cycle:
  - skip_cnt!=0: go to SKIP, skip_cnt <= skip_cnt-1.
  - skip_cnt==0 and buf_ready=1: go to PASS, skip_cnt <= skip_n. In that same cycle vsync_out <= 1 and data_out_valid <= data_in_valid, so the first byte is not lost.
  - skip_cnt==0 and buf_ready=0: go to SKIP, drop_count += 1 (saturating at all-ones), skip_cnt stays 0 so the next frame is a candidate.
- PASS:
  - While vsync_in=1: vsync_out <= 1, data_out_valid <= data_in_valid.
  - On fall: vsync_out <= 0, data_out_valid <= 0, frame_count += 1 (wraps), go to ARMED.
  - buf_ready is ignored mid-frame.
- SKIP: outputs low. On fall, go to ARMED.
- data_in_valid while vsync_in=0 is never forwarded in any state.
- init_done falling in any state:
  - Next cycle state=WAIT_INIT, vsync_out=0, data_out_valid=0.
  - A truncated frame is not counted in frame_count.
  - skip_cnt is cleared.
- rise and fall cannot coincide (single-bit input). A 1-cycle vsync pulse gives rise then fall on consecutive cycles:
  - In PASS, one cycle of vsync_out and frame_count += 1.
  - In SKIP, nothing is output.
- skip_n=0 means every frame is a candidate.
- nreset asserted mid-frame: all outputs low immediately (async). After release the FSM restarts from WAIT_INIT.

Decomposition:
- Shared package holds the state encoding constants (WAIT_INIT..SKIP) for reuse by debug/LED logic.
- One natural sub-module: vsync_edge_detect (vsync_q register plus rise/fall outputs, async active-low reset). It is reusable by the stuffer and the LED divider.
- Everything else stays in one FSM block.

Test Plan:
1. init_done=0, three vsync frames of 10 bytes -> zero data_out_valid pulses. Raise init_done mid-frame -> that frame is still dropped (WAIT_IDLE), the next frame passes, frame_count=1.
2. skip_n=2, buf_ready=1, 6 frames -> frames 1 and 4 pass (10 valid bytes each, 1-cycle latency, matching bytes), frame_count=2, drop_count=0.
3. skip_n=0, buf_ready=0 at frames 2 and 3 rise, toggled high mid-frame 1 -> frames 1 and 4 pass; drop_count=2; buf_ready toggling inside frame 1 does not truncate it.
4. 300 frames with buf_ready=0 -> drop_count saturates at 255, frame_count=0. Run 65537 passed frames (short frames) -> frame_count wraps to 1.
5. init_done drops during byte 5 of a passing frame -> next cycle vsync_out=0, valid=0; frame_count unchanged; re-enable -> resumes at next full frame.
6. nreset pulsed low mid-PASS -> outputs and counters 0 asynchronously; after release, the partially seen frame is not forwarded.
